// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB slave types and constants
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_WAIT,
        APB_ACCESS
    } apb_state_t;

    localparam logic APB_OKAY   = 1'b0;
    localparam logic APB_SLVERR = 1'b1;

    // Wait counter is sized for WAIT_CYCLES up to 15
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_ram_array.sv
// rtl/apb_ram_array.sv - word RAM with byte-enable write, async read, async clear
module apb_ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-lane writes; whole array clears on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_ram_slave.sv
// rtl/apb_ram_slave.sv - APB3 slave with internal RAM, wait states and error response
module apb_ram_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int AL      = $clog2(DATA_W/8);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        NO_WAIT ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    apb_state_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    write_q, write_d;
    logic [DATA_W-1:0]       prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;

    logic                    misaligned;
    logic                    out_of_range;
    logic                    err_now;
    logic [IDX_W-1:0]        idx_now;
    logic [IDX_W-1:0]        ram_raddr;
    logic [DATA_W-1:0]       ram_rdata;
    logic                    ram_we;

    // Byte-wide buses have no alignment bits
    if (AL == 0) begin : g_no_align
        assign misaligned = 1'b0;
    end else begin : g_align
        assign misaligned = |paddr[AL-1:0];
    end

    // Any set bit above the word index means idx >= DEPTH; no truncation aliasing
    assign out_of_range = |(paddr >> (AL + IDX_W));
    assign err_now      = misaligned | out_of_range;
    assign idx_now      = paddr[AL +: IDX_W];

    // Setup reads straight from the bus address; later phases use the captured index
    assign ram_raddr = (state_q == APB_IDLE) ? idx_now : idx_q;

    apb_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (pclk),
        .rst   (preset),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (pwdata),
        .wstrb (pstrb),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Next-state, wait counting and registered response selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        idx_d     = idx_q;
        write_d   = write_q;
        pready_d  = 1'b0;
        pslverr_d = APB_OKAY;
        prdata_d  = '0;
        ram_we    = 1'b0;
        case (state_q)
            APB_IDLE: begin
                if (psel && !penable) begin
                    err_d   = err_now;
                    idx_d   = idx_now;
                    write_d = pwrite;
                    if (NO_WAIT) begin
                        state_d   = APB_ACCESS;
                        pready_d  = 1'b1;
                        pslverr_d = err_now ? APB_SLVERR : APB_OKAY;
                        prdata_d  = (!pwrite && !err_now) ? ram_rdata : '0;
                    end else begin
                        state_d = APB_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            APB_WAIT: begin
                if (!psel) begin
                    state_d = APB_IDLE;
                end else if (penable) begin
                    if (cnt_q == '0) begin
                        state_d   = APB_ACCESS;
                        pready_d  = 1'b1;
                        pslverr_d = err_q ? APB_SLVERR : APB_OKAY;
                        prdata_d  = (!write_q && !err_q) ? ram_rdata : '0;
                    end else begin
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end
                end
            end
            APB_ACCESS: begin
                state_d = APB_IDLE;
                ram_we  = psel && penable && pwrite && !err_q;
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase
    end

    // State, capture and output registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= APB_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= APB_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram_slave.sv
// tb/tb_apb_ram_slave.sv - directed bench for apb_ram_slave (no-wait and 3-wait instances)
module tb_apb_ram_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic [35:0] paddr;
    logic        psel0, psel1, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb_ram_slave #(.DATA_W(32), .ADDR_W(36), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_ram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(3)) dut1 (
        .pclk(pclk), .preset(preset), .paddr(paddr[31:0]), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    typedef struct {
        bit          wr;
        logic [35:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic cur_pready(input bit sel1);
        return sel1 ? pready1 : pready0;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends the transfer
    task automatic xfer(input bit sel1, input bit wr, input logic [35:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int waits);
        psel0 = !sel1; psel1 = sel1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0; rd = '0; er = 1'b0;
        while (!cur_pready(sel1) && waits < 40) begin
            @(posedge pclk); #1;
            waits++;
        end
        if (cur_pready(sel1)) begin
            rd = sel1 ? prdata1 : prdata0;
            er = sel1 ? pslverr1 : pslverr0;
        end else begin
            chk("pready_timeout", 32'(cur_pready(sel1)), 32'd1);
        end
        @(posedge pclk); #1;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        chk("pready_one_cycle", 32'(cur_pready(sel1)), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          waits;

    initial begin
        preset = 1'b1; psel0 = 0; psel1 = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; pstrb = '0;

        vecs.push_back('{1'b0, 36'h008, 32'h0,        4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 36'h008, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 36'h008, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 36'h004, 32'h11223344, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 36'h004, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 36'h004, 32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 36'h040, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 36'h000, 32'h0,        4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 36'h03C, 32'h0,        4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 36'h006, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 36'h1_0000_0000, 32'h12345678, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 36'h1_0000_0000, 32'h0, 4'h0, 32'h0,       1'b1});
        vecs.push_back('{1'b0, 36'h000, 32'h0,        4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 36'h00C, 32'h55555555, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 36'h00C, 32'h0,        4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 36'h040, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 36'h03C, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 36'h03C, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0});
        vecs.push_back('{1'b0, 36'h008, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});

        repeat (3) @(posedge pclk);
        #1;
        chk("reset_pready0", 32'(pready0), 32'd0);
        chk("reset_pslverr0", 32'(pslverr0), 32'd0);
        chk("reset_prdata0", prdata0, 32'd0);
        chk("reset_pready1", 32'(pready1), 32'd0);
        preset = 1'b0;
        @(posedge pclk); #1;

        // Table vectors run back to back on the no-wait instance
        foreach (vecs[i]) begin
            xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, waits);
            chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_waits", i), 32'(waits), 32'd0);
        end

        // Back-to-back write then read of word 0
        xfer(1'b0, 1'b1, 36'h000, 32'h600DF00D, 4'hF, rd, er, waits);
        xfer(1'b0, 1'b0, 36'h000, 32'h0, 4'h0, rd, er, waits);
        chk("b2b_raw_prdata", rd, 32'h600DF00D);

        // Three wait states
        xfer(1'b1, 1'b1, 36'h010, 32'hCAFEF00D, 4'hF, rd, er, waits);
        chk("w3_write_waits", 32'(waits), 32'd3);
        chk("w3_write_err", 32'(er), 32'd0);
        xfer(1'b1, 1'b0, 36'h010, 32'h0, 4'h0, rd, er, waits);
        chk("w3_read_waits", 32'(waits), 32'd3);
        chk("w3_read_prdata", rd, 32'hCAFEF00D);

        // Abort: psel dropped in the second wait cycle
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 36'h010;
        pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        chk("abort_wait1_pready", 32'(pready1), 32'd0);
        @(posedge pclk); #1;
        chk("abort_wait2_pready", 32'(pready1), 32'd0);
        psel1 = 1'b0; penable = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        chk("abort_idle_pready", 32'(pready1), 32'd0);
        chk("abort_idle_pslverr", 32'(pslverr1), 32'd0);
        xfer(1'b1, 1'b0, 36'h010, 32'h0, 4'h0, rd, er, waits);
        chk("abort_nowrite_prdata", rd, 32'hCAFEF00D);
        chk("abort_after_waits", 32'(waits), 32'd3);

        // Reset asserted mid-wait
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 36'h014;
        pwdata = 32'h77777777; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        chk("rst_mid_pready", 32'(pready1), 32'd0);
        chk("rst_mid_pslverr", 32'(pslverr1), 32'd0);
        chk("rst_mid_prdata", prdata1, 32'd0);
        @(posedge pclk); #1;
        chk("rst_next_pready", 32'(pready1), 32'd0);
        preset = 1'b0; psel1 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        xfer(1'b0, 1'b0, 36'h008, 32'h0, 4'h0, rd, er, waits);
        chk("rst_clear_dut0_w2", rd, 32'h0);
        xfer(1'b1, 1'b0, 36'h010, 32'h0, 4'h0, rd, er, waits);
        chk("rst_clear_dut1_w4", rd, 32'h0);
        xfer(1'b1, 1'b0, 36'h014, 32'h0, 4'h0, rd, er, waits);
        chk("rst_clear_dut1_w5", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
